// File: rtl/vx_ram_reader_pkg.sv
// Shared helpers for the RAM burst reader.
package vx_ram_reader_pkg;

  // Entries in the output buffer; also the bound on words owned by the reader.
  localparam int unsigned BufDepth = 2;

  // True when one more read can be issued without overrunning the output buffer,
  // counting buffered words, the word returning this cycle and a pop this cycle.
  function automatic logic can_issue(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    int fill;
    fill = int'(occ) + int'(inflight) - int'(pop);
    return fill < int'(BufDepth);
  endfunction

endpackage

// File: rtl/vx_ram_reader_if.sv
// Request, RAM read port and output stream of the burst reader.
interface vx_ram_reader_if #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned ADDRW = 6
);
  logic             req_valid;
  logic [ADDRW-1:0] req_addr;
  logic [ADDRW:0]   req_count;
  logic             req_ready;

  logic             ram_rden;
  logic [ADDRW-1:0] ram_raddr;
  logic [DATAW-1:0] ram_rdata;

  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  // Reader side
  modport master (
    input  req_valid, req_addr, req_count, ram_rdata, out_ready,
    output req_ready, ram_rden, ram_raddr, out_valid, out_data, out_last
  );

  // Requester / RAM / consumer side
  modport slave (
    output req_valid, req_addr, req_count, ram_rdata, out_ready,
    input  req_ready, ram_rden, ram_raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/vx_skid_buffer.sv
// Two-entry registered FIFO with valid/ready on both sides.
module vx_skid_buffer #(
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       cnt_q;
  logic             push, pop;

  // Head is served straight from storage; a full buffer still takes a word when popping.
  always_comb begin
    out_valid_o = (cnt_q != 2'd0);
    out_data_o  = mem_q[rd_ptr_q];
    in_ready_o  = (cnt_q != 2'd2) || out_ready_i;
    push        = in_valid_i && in_ready_o;
    pop         = out_valid_o && out_ready_i;
    count_o     = cnt_q;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vx_ram_reader.sv
// Streams a burst of words out of a registered-output RAM with a 2-word output buffer.
module vx_ram_reader
  import vx_ram_reader_pkg::*;
#(
  parameter int unsigned DATAW = 32,
  parameter int unsigned SIZE  = 64,
  parameter int unsigned ADDRW = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            reset,
  vx_ram_reader_if.master bus,
  output logic            busy
);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d, raddr_q, next_addr;
  logic [ADDRW:0]   count_q, count_d;
  logic             inflight_q, inflight_last_q;
  logic             accept, issue, pop, last_read, buf_in_ready;
  logic [1:0]       occ;
  logic [DATAW:0]   buf_out;

  assign accept    = bus.req_valid && bus.req_ready;
  assign pop       = bus.out_valid && bus.out_ready;
  assign last_read = (count_q == (ADDRW+1)'(1));
  assign next_addr = (addr_q == ADDRW'(SIZE - 1)) ? '0 : addr_q + ADDRW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: zero-length bursts never leave idle; leave read after the final issue.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && bus.req_count != '0) state_d = StRead;
      StRead: if (issue && last_read) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: handshake, read issue and busy are all held low while in reset.
  always_comb begin
    bus.req_ready = !reset && state_q == StIdle && occ == 2'd0 && !inflight_q;
    issue         = !reset && state_q == StRead && can_issue(occ, inflight_q, pop);
    bus.ram_rden  = issue;
    bus.ram_raddr = issue ? addr_q : raddr_q;
    busy          = !reset && (state_q == StRead || occ != 2'd0 || inflight_q);
  end

  // Burst address/count bookkeeping.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (accept && bus.req_count != '0) begin
      addr_d  = bus.req_addr;
      count_d = bus.req_count;
    end else if (issue) begin
      addr_d  = next_addr;
      count_d = count_q - (ADDRW+1)'(1);
    end
  end

  // Datapath registers; the in-flight flag marks ram_rdata to be captured next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q          <= '0;
      count_q         <= '0;
      raddr_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      count_q         <= count_d;
      if (issue) raddr_q <= addr_q;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_read;
    end
  end

  // A returning word must always find room; the issue window guarantees it.
  always_ff @(posedge clk) begin
    if (!reset && inflight_q) begin
      a_room: assert (buf_in_ready);
    end
  end

  vx_skid_buffer #(
    .Width (DATAW + 1)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (inflight_q),
    .in_data_i   ({inflight_last_q, bus.ram_rdata}),
    .in_ready_o  (buf_in_ready),
    .out_valid_o (bus.out_valid),
    .out_data_o  (buf_out),
    .out_ready_i (bus.out_ready),
    .count_o     (occ)
  );

  assign bus.out_last = buf_out[DATAW];
  assign bus.out_data = buf_out[DATAW-1:0];

endmodule

// File: tb/tb_vx_ram_reader.sv
// Scoreboard bench for the RAM burst reader.
module tb_vx_ram_reader;
  localparam int unsigned DATAW = 32;
  localparam int unsigned SIZE  = 64;
  localparam int unsigned ADDRW = $clog2(SIZE);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;

  vx_ram_reader_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

  vx_ram_reader #(.DATAW(DATAW), .SIZE(SIZE), .ADDRW(ADDRW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [DATAW-1:0] mem [SIZE];
  logic [DATAW-1:0] exp_data_q [$];
  logic             exp_last_q [$];
  logic [ADDRW-1:0] exp_addr_q [$];
  int n_vec = 0;
  int n_err = 0;
  int spurious = 0;
  int lasts = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Registered-output RAM model.
  always @(posedge clk) begin
    if (bus.ram_rden) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  // Consumer ready pattern, changed just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: read addresses and output words against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_rden) begin
        if (exp_addr_q.size() == 0) spurious++;
        else check_eq("raddr", 64'(bus.ram_raddr), 64'(exp_addr_q.pop_front()));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_last) lasts++;
        if (exp_data_q.size() == 0) begin
          spurious++;
        end else begin
          check_eq("data", 64'(bus.out_data), 64'(exp_data_q.pop_front()));
          check_eq("last", 64'(bus.out_last), 64'(exp_last_q.pop_front()));
        end
      end
    end
  end

  // Waits for req_ready at a falling edge, presents the request for one cycle and
  // returns just after the accepting edge.
  task automatic send_req(input int addr, input int count);
    int i = 0;
    @(negedge clk);
    while (!bus.req_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    check_eq("req_ready_wait", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = ADDRW'(addr);
    bus.req_count = (ADDRW+1)'(count);
    for (int k = 0; k < count; k++) begin
      int unsigned a;
      a = (int'(addr) + k) % SIZE;
      exp_addr_q.push_back(ADDRW'(a));
      exp_data_q.push_back(mem[a]);
      exp_last_q.push_back(k == count - 1);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lasts);
    int i = 0;
    @(negedge clk);
    while ((busy || exp_data_q.size() != 0) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    check_eq({tag, "_pending"}, 64'(exp_data_q.size()), 64'd0);
    check_eq({tag, "_spurious"}, 64'(spurious), 64'd0);
    check_eq({tag, "_lasts"}, 64'(lasts), 64'(exp_lasts));
    spurious = 0;
    lasts    = 0;
  endtask

  initial begin
    int i;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_count = '0;
    for (int k = 0; k < SIZE; k++) mem[k] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_rden", 64'(bus.ram_rden), 64'd0);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_raddr", 64'(bus.ram_raddr), 64'd0);
    check_eq("rst_out_data", 64'(bus.out_data), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // addr=5 count=4: issue at T+1, words on T+3..T+6
    send_req(5, 4);
    @(negedge clk);
    check_eq("t1_issue", 64'(bus.ram_rden), 64'd1);
    @(negedge clk);
    check_eq("t2_no_valid", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t3_valid", 64'(bus.out_valid), 64'd1);
      check_eq("t3_last", 64'(bus.out_last), 64'(k == 3));
    end
    wait_done("basic", 1);

    // Address wrap 62,63,0,1
    send_req(62, 4);
    wait_done("wrap", 1);

    // Backpressure: stall 5 cycles after the first word
    send_req(10, 8);
    i = 0;
    @(negedge clk);
    while (!bus.out_valid && i < 50) begin
      @(negedge clk);
      i++;
    end
    check_eq("bp_first_valid", 64'(bus.out_valid), 64'd1);
    ready_mode = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_stall_rden", 64'(bus.ram_rden), 64'd0);
      check_eq("bp_stall_valid", 64'(bus.out_valid), 64'd1);
    end
    ready_mode = 0;
    wait_done("bp", 1);

    // Zero-length burst
    send_req(20, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("zero_req_ready", 64'(bus.req_ready), 64'd1);
      check_eq("zero_rden", 64'(bus.ram_rden), 64'd0);
      check_eq("zero_valid", 64'(bus.out_valid), 64'd0);
    end
    wait_done("zero", 0);

    // Reset two cycles into a 16-word burst
    send_req(0, 16);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_data_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    check_eq("abort_req_ready_in_rst", 64'(bus.req_ready), 64'd0);
    check_eq("abort_rden_in_rst", 64'(bus.ram_rden), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("abort_valid", 64'(bus.out_valid), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("abort_out_data", 64'(bus.out_data), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("abort_quiet", 64'(bus.out_valid), 64'd0);
    end
    wait_done("abort", 0);

    // Full-size burst with random consumer
    ready_mode = 1;
    send_req(int'($urandom_range(0, SIZE - 1)), SIZE);
    wait_done("random", 1);
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_ram_reader.md
VX_RAM_READER -- requirements
Module: VX_ram_reader

Interface
REQ-001 SHALL have parameter DATAW, default 32: data word width in bits.
REQ-002 SHALL have parameter SIZE, default 64: number of RAM words.
REQ-003 SHALL have parameter ADDRW, default $clog2(SIZE): RAM address width.
REQ-004 SHALL have port clk  input  1  clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  burst request valid.
REQ-007 SHALL have port req_addr  input  ADDRW  burst start address.
REQ-008 SHALL have port req_count  input  ADDRW+1  words to read, 0..SIZE.
REQ-009 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-010 SHALL have port ram_rden  output  1  read issued this cycle.
REQ-011 SHALL have port ram_raddr  output  ADDRW  RAM read address.
REQ-012 SHALL have port ram_rdata  input  DATAW  RAM read data, valid exactly 1 cycle after the issuing cycle (registered-output RAM).
REQ-013 SHALL have port out_valid  output  1  stream word valid.
REQ-014 SHALL have port out_data  output  DATAW  stream word.
REQ-015 SHALL have port out_last  output  1  final word of burst.
REQ-016 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-017 SHALL have port busy  output  1  burst in progress or words pending.

Function
REQ-018 SHALL have a two-state FSM: IDLE and READ.
REQ-019 SHALL assert req_ready only in IDLE with no pending or in-flight words.
REQ-020 SHALL, in IDLE, on accept with req_count>0, latch req_addr/req_count and go to READ.
REQ-021 SHALL, on accept with req_count==0, stay in IDLE and produce no output words.
REQ-022 SHALL, in READ, issue a read (ram_rden=1) when occupancy+inflight-pop < 2; occupancy counts buffer entries, inflight counts a read issued last cycle, pop is out_valid&&out_ready this cycle.
REQ-023 SHALL increment the address after each issued read, wrapping from SIZE-1 to 0.
REQ-024 SHALL decrement the remaining count per issued read and return to IDLE after issuing the last read.
REQ-025 SHALL write ram_rdata into a 2-entry output buffer in the cycle after issue, tagging it last when it was the burst's final read.
REQ-026 SHALL drive out_valid/out_data/out_last from the buffer head only (registered; no ram_rdata-to-out path).
REQ-027 SHALL give first-word latency of 3 cycles: accept in T, issue in T+1, out_valid high in T+3.
REQ-028 SHALL sustain one word per cycle while out_ready is held high.
REQ-029 SHALL hold out_data/out_last stable while out_valid && !out_ready.
REQ-030 SHALL handle push and pop in the same cycle with the buffer full without loss or duplication.
REQ-031 SHALL hold ram_raddr at its last value when ram_rden=0.
REQ-032 SHALL drive busy = (state==READ) || occupancy!=0 || inflight.

Reset
REQ-033 SHALL, on reset, enter IDLE, clear occupancy, inflight, address and count, and drive req_ready=0 during reset, ram_rden=0, out_valid=0, out_last=0, busy=0, ram_raddr=0, and out_data=0.
REQ-034 SHALL abort a burst on reset mid-operation, discarding buffered and in-flight words; ram_rdata returning in the cycle after reset SHALL be ignored.

Structure
REQ-035 SHALL keep the FSM state enum local; no new shared-package typedefs or constants are required.
REQ-036 SHALL implement the output buffer as one sub-module, VX_skid_buffer (2 entries, DATAW+1 bits, valid/ready both sides).

Verification
REQ-037 SHALL cover: addr=5, count=4, out_ready=1 -> words ram[5..8] on 4 consecutive cycles starting T+3, out_last on ram[8].
REQ-038 SHALL cover: SIZE=64, addr=62, count=4 -> reads 62,63,0,1 in that order, out_last on word from address 1.
REQ-039 SHALL cover: count=8, out_ready low 5 cycles after first word -> at most 2 buffered plus 0 in flight, no loss, 8 words in order.
REQ-040 SHALL cover: count=0 -> no ram_rden, no out_valid, req_ready high the next cycle.
REQ-041 SHALL cover: reset asserted 2 cycles into a count=16 burst -> next cycle out_valid=0, busy=0, req_ready=1 after reset release.
REQ-042 SHALL cover: random out_ready (50%), count=SIZE -> exactly SIZE words matching RAM contents, exactly one out_last.
